// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural register file with register renaming.
// Each register holds a committed value or, while a producer is in flight,
// the ROB tag of that producer. NWR rename, NCM commit and NRD combinational
// read ports; higher channel index is the younger instruction and wins.
// Optional build macro: RENAME_RF_CKPT_EN adds a single branch checkpoint of
// the tag state (ckpt_save_i / ckpt_recover_i).
module rename_reg_file #(
  parameter int NREG = 34,
  parameter int DW   = 32,
  parameter int ROBW = 5,
  parameter int NWR  = 2,
  parameter int NCM  = 2,
  parameter int NRD  = 4,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      rename_en_i,
  input  logic [NWR*AW-1:0]   rename_addr_i,
  input  logic [NWR*ROBW-1:0] rename_id_i,
  input  logic [NCM-1:0]      commit_en_i,
  input  logic [NCM*AW-1:0]   commit_addr_i,
  input  logic [NCM*ROBW-1:0] commit_id_i,
  input  logic [NCM*DW-1:0]   commit_data_i,
  input  logic                restore_i,
`ifdef RENAME_RF_CKPT_EN
  input  logic                ckpt_save_i,
  input  logic                ckpt_recover_i,
`endif
  input  logic [NRD*AW-1:0]   read_addr_i,
  output logic [NRD-1:0]      read_is_ref_o,
  output logic [NRD*DW-1:0]   read_data_o
);

  logic [DW-1:0]   val_q      [NREG];
  logic [DW-1:0]   val_d      [NREG];
  logic [NREG-1:0] isref_q, isref_d;
  logic [ROBW-1:0] refid_q    [NREG];
  logic [ROBW-1:0] refid_d    [NREG];

  // Per-register view of this cycle's rename/commit traffic (youngest channel).
  logic [NREG-1:0] rn_hit, cm_hit;
  logic [ROBW-1:0] rn_id      [NREG];
  logic [ROBW-1:0] cm_id      [NREG];
  logic [DW-1:0]   cm_data    [NREG];

  // Tag state that this cycle's commits act on: live state, or the snapshot
  // while a branch recovery is in progress.
  logic [NREG-1:0] base_isref;
  logic [ROBW-1:0] base_refid [NREG];
  logic            recover;

  logic [AW-1:0]   rd_addr    [NRD];

  // Decode channels per register; ascending scan lets the younger channel win.
  // Register 0 and out-of-range addresses never match any register.
  always_comb begin
    rn_hit = '0;
    cm_hit = '0;
    for (int r = 0; r < NREG; r++) begin
      rn_id[r]   = '0;
      cm_id[r]   = '0;
      cm_data[r] = '0;
    end
    for (int r = 1; r < NREG; r++) begin
      for (int i = 0; i < NWR; i++) begin
        if (rename_en_i[i] && rename_addr_i[i*AW +: AW] == AW'(r)) begin
          rn_hit[r] = 1'b1;
          rn_id[r]  = rename_id_i[i*ROBW +: ROBW];
        end
      end
      for (int i = 0; i < NCM; i++) begin
        if (commit_en_i[i] && commit_addr_i[i*AW +: AW] == AW'(r)) begin
          cm_hit[r]  = 1'b1;
          cm_id[r]   = commit_id_i[i*ROBW +: ROBW];
          cm_data[r] = commit_data_i[i*DW +: DW];
        end
      end
    end
  end

`ifdef RENAME_RF_CKPT_EN
  logic [NREG-1:0] snap_isref_q;
  logic [ROBW-1:0] snap_refid_q [NREG];

  // A flush outranks a branch recovery.
  assign recover = ckpt_recover_i & ~restore_i;

  // Select snapshot or live tags as the base for this cycle.
  always_comb begin
    base_isref = recover ? snap_isref_q : isref_q;
    for (int r = 0; r < NREG; r++) begin
      base_refid[r] = recover ? snap_refid_q[r] : refid_q[r];
    end
  end

  // Snapshot captures next-state tags; a recover in the same cycle keeps it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_isref_q <= '0;
      for (int r = 0; r < NREG; r++) snap_refid_q[r] <= '0;
    end else if (ckpt_save_i && !ckpt_recover_i) begin
      snap_isref_q <= isref_d;
      snap_refid_q <= refid_d;
    end
  end
`else
  assign recover = 1'b0;

  // Without checkpointing the live tags are always the base.
  always_comb begin
    base_isref = isref_q;
    for (int r = 0; r < NREG; r++) base_refid[r] = refid_q[r];
  end
`endif

  // Next state: commits always write val; tags follow flush/recover/rename/commit.
  always_comb begin
    isref_d = '0;
    for (int r = 0; r < NREG; r++) begin
      val_d[r]   = val_q[r];
      refid_d[r] = refid_q[r];
    end
    for (int r = 1; r < NREG; r++) begin
      if (cm_hit[r]) val_d[r] = cm_data[r];
      if (!restore_i) begin
        isref_d[r] = base_isref[r];
        refid_d[r] = base_refid[r];
        if (!recover && rn_hit[r]) begin
          isref_d[r] = 1'b1;
          refid_d[r] = rn_id[r];
        end else if (cm_hit[r] && base_refid[r] == cm_id[r]) begin
          isref_d[r] = 1'b0;
        end
      end
    end
  end

  // Architectural state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      isref_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        val_q[r]   <= '0;
        refid_q[r] <= '0;
      end
    end else begin
      isref_q <= isref_d;
      val_q   <= val_d;
      refid_q <= refid_d;
    end
  end

  // Combinational read ports with same-cycle rename/commit bypass.
  always_comb begin
    read_is_ref_o = '0;
    read_data_o   = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_addr[p] = read_addr_i[p*AW +: AW];
      if (rst && rd_addr[p] != '0 && {1'b0, rd_addr[p]} < (AW+1)'(NREG)) begin
        if (restore_i) begin
          read_data_o[p*DW +: DW] = cm_hit[rd_addr[p]] ? cm_data[rd_addr[p]]
                                                      : val_q[rd_addr[p]];
        end else if (!recover && rn_hit[rd_addr[p]]) begin
          read_is_ref_o[p]        = 1'b1;
          read_data_o[p*DW +: DW] = DW'(rn_id[rd_addr[p]]);
        end else if (cm_hit[rd_addr[p]] &&
                     (!base_isref[rd_addr[p]] ||
                      base_refid[rd_addr[p]] == cm_id[rd_addr[p]])) begin
          read_data_o[p*DW +: DW] = cm_data[rd_addr[p]];
        end else if (base_isref[rd_addr[p]]) begin
          read_is_ref_o[p]        = 1'b1;
          read_data_o[p*DW +: DW] = DW'(base_refid[rd_addr[p]]);
        end else begin
          read_data_o[p*DW +: DW] = val_q[rd_addr[p]];
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Bench for rename_reg_file: directed scenarios followed by random traffic
// checked against a register-level behavioural model.
module tb_rename_reg_file;
  localparam int NREG = 34, DW = 32, ROBW = 5, NWR = 2, NCM = 2, NRD = 4;
  localparam int AW = $clog2(NREG);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NWR-1:0]      rename_en;
  logic [NWR*AW-1:0]   rename_addr;
  logic [NWR*ROBW-1:0] rename_id;
  logic [NCM-1:0]      commit_en;
  logic [NCM*AW-1:0]   commit_addr;
  logic [NCM*ROBW-1:0] commit_id;
  logic [NCM*DW-1:0]   commit_data;
  logic                restore;
  logic                ckpt_save, ckpt_recover;
  logic [NRD*AW-1:0]   read_addr;
  logic [NRD-1:0]      read_is_ref;
  logic [NRD*DW-1:0]   read_data;

  int errors = 0;
  int checks = 0;
  int rda [NRD];

  // Reference model state
  logic [DW-1:0]   m_val [NREG];
  bit              m_ref [NREG];
  logic [ROBW-1:0] m_id  [NREG];
  bit              s_ref [NREG];
  logic [ROBW-1:0] s_id  [NREG];

  rename_reg_file dut (
    .clk           (clk),
    .rst           (rst),
    .rename_en_i   (rename_en),
    .rename_addr_i (rename_addr),
    .rename_id_i   (rename_id),
    .commit_en_i   (commit_en),
    .commit_addr_i (commit_addr),
    .commit_id_i   (commit_id),
    .commit_data_i (commit_data),
    .restore_i     (restore),
`ifdef RENAME_RF_CKPT_EN
    .ckpt_save_i   (ckpt_save),
    .ckpt_recover_i(ckpt_recover),
`endif
    .read_addr_i   (read_addr),
    .read_is_ref_o (read_is_ref),
    .read_data_o   (read_data)
  );

  function automatic logic [DW:0] E(bit r, logic [DW-1:0] d);
    return {r, d};
  endfunction

  // Youngest rename channel targeting register a, or -1.
  function automatic int win_ren(int a);
    for (int i = NWR-1; i >= 0; i--)
      if (rename_en[i] && int'(rename_addr[i*AW +: AW]) == a) return i;
    return -1;
  endfunction

  function automatic int win_cmt(int a);
    for (int i = NCM-1; i >= 0; i--)
      if (commit_en[i] && int'(commit_addr[i*AW +: AW]) == a) return i;
    return -1;
  endfunction

  // Expected {is_ref, data} for a read of register a under current inputs.
  function automatic logic [DW:0] m_read(int a);
    int rw, cw;
    bit bref;
    logic [ROBW-1:0] bid;
    logic [DW-1:0] cd;
    if (!rst || a == 0 || a >= NREG) return '0;
    rw = win_ren(a);
    cw = win_cmt(a);
    cd = (cw >= 0) ? commit_data[cw*DW +: DW] : '0;
    if (restore) return {1'b0, (cw >= 0) ? cd : m_val[a]};
    bref = ckpt_recover ? s_ref[a] : m_ref[a];
    bid  = ckpt_recover ? s_id[a]  : m_id[a];
    if (!ckpt_recover && rw >= 0) return {1'b1, DW'(rename_id[rw*ROBW +: ROBW])};
    if (cw >= 0 && (!bref || bid == commit_id[cw*ROBW +: ROBW])) return {1'b0, cd};
    if (bref) return {1'b1, DW'(bid)};
    return {1'b0, m_val[a]};
  endfunction

  // Advance the model by one clock edge using the inputs applied this cycle.
  task automatic model_step();
    bit              nref [NREG];
    logic [ROBW-1:0] nid  [NREG];
    int rw, cw;
    if (!rst) begin
      for (int a = 0; a < NREG; a++) begin
        m_val[a] = '0; m_ref[a] = 0; m_id[a] = '0; s_ref[a] = 0; s_id[a] = '0;
      end
      return;
    end
    for (int a = 0; a < NREG; a++) begin
      nref[a] = m_ref[a];
      nid[a]  = m_id[a];
      if (a == 0) continue;
      rw = win_ren(a);
      cw = win_cmt(a);
      if (cw >= 0) m_val[a] = commit_data[cw*DW +: DW];
      if (restore) begin
        nref[a] = 0;
      end else begin
        if (ckpt_recover) begin
          nref[a] = s_ref[a];
          nid[a]  = s_id[a];
        end
        if (!ckpt_recover && rw >= 0) begin
          nref[a] = 1;
          nid[a]  = rename_id[rw*ROBW +: ROBW];
        end else if (cw >= 0 && commit_id[cw*ROBW +: ROBW] == nid[a]) begin
          nref[a] = 0;
        end
      end
    end
    if (ckpt_save && !ckpt_recover) begin
      s_ref = nref;
      s_id  = nid;
    end
    m_ref = nref;
    m_id  = nid;
  endtask

  task automatic idle();
    rename_en = '0; rename_addr = '0; rename_id = '0;
    commit_en = '0; commit_addr = '0; commit_id = '0; commit_data = '0;
    restore = 1'b0; ckpt_save = 1'b0; ckpt_recover = 1'b0;
    read_addr = '0;
    for (int p = 0; p < NRD; p++) rda[p] = 0;
  endtask

  task automatic ren(int ch, int a, int id);
    rename_en[ch] = 1'b1;
    rename_addr[ch*AW +: AW] = AW'(a);
    rename_id[ch*ROBW +: ROBW] = ROBW'(id);
  endtask

  task automatic cmt(int ch, int a, int id, logic [DW-1:0] d);
    commit_en[ch] = 1'b1;
    commit_addr[ch*AW +: AW] = AW'(a);
    commit_id[ch*ROBW +: ROBW] = ROBW'(id);
    commit_data[ch*DW +: DW] = d;
  endtask

  task automatic rd(int p, int a);
    read_addr[p*AW +: AW] = AW'(a);
    rda[p] = a;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk(string tag, int p, logic [DW:0] exp);
    logic [DW:0] got;
    #1;
    got = {read_is_ref[p], read_data[p*DW +: DW]};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s port%0d: got is_ref=%0b data=%h, expected is_ref=%0b data=%h",
             tag, p, got[DW], got[DW-1:0], exp[DW], exp[DW-1:0]);
    end
  endtask

  function automatic int raddr();
    return ($urandom_range(0, 9) < 8) ? $urandom_range(0, 7) : $urandom_range(0, 35);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a;
    for (int r = 0; r < NREG; r++) begin
      m_val[r] = '0; m_ref[r] = 0; m_id[r] = '0; s_ref[r] = 0; s_id[r] = '0;
    end
    idle();
    rst = 1'b0;
    tick();
    rd(0, 5);
    chk("in_reset", 0, E(0, 0));
    tick();
    rst = 1'b1;

    // T1: reset state; register 0 cannot be renamed
    rd(0, 5);
    chk("t1_r5", 0, E(0, 0));
    ren(0, 0, 3); rd(1, 0);
    chk("t1_r0_same", 1, E(0, 0));
    tick(); idle(); rd(1, 0);
    chk("t1_r0_next", 1, E(0, 0));

    // T2: two channels rename r5, younger wins
    ren(0, 5, 7); ren(1, 5, 9); rd(0, 5);
    chk("t2_same", 0, E(1, 9));
    tick(); idle(); rd(0, 5);
    chk("t2_next", 0, E(1, 9));

    // T3: stale commit keeps tag, matching commit frees it
    cmt(0, 5, 7, 32'h11); rd(0, 5);
    chk("t3_stale", 0, E(1, 9));
    tick(); idle();
    cmt(1, 5, 9, 32'h22); rd(0, 5);
    chk("t3_match", 0, E(0, 32'h22));
    tick(); idle(); rd(0, 5);
    chk("t3_after", 0, E(0, 32'h22));

    // T4: rename beats matching commit on the same register
    ren(0, 6, 2);
    tick(); idle();
    ren(1, 6, 4); cmt(0, 6, 2, 32'h66); rd(2, 6);
    chk("t4_same", 2, E(1, 4));
    tick(); idle(); rd(2, 6);
    chk("t4_next", 2, E(1, 4));
    restore = 1'b1; rd(2, 6);
    chk("t4_val", 2, E(0, 32'h66));
    tick(); idle();

    // T5: restore with a forwarded commit, tags dropped afterwards
    ren(0, 1, 1); ren(1, 2, 2);
    tick(); idle();
    ren(0, 3, 3);
    tick(); idle();
    rd(0, 1); rd(1, 2); rd(2, 3); rd(3, 5);
    chk("t5_pre_r1", 0, E(1, 1));
    restore = 1'b1; ren(1, 4, 8); cmt(0, 2, 30, 32'hAB);
    chk("t5_r1", 0, E(0, 0));
    chk("t5_r2", 1, E(0, 32'hAB));
    chk("t5_r3", 2, E(0, 0));
    chk("t5_r5", 3, E(0, 32'h22));
    tick(); idle();
    rd(0, 1); rd(1, 2); rd(2, 3); rd(3, 4);
    chk("t5_after_r1", 0, E(0, 0));
    chk("t5_after_r2", 1, E(0, 32'hAB));
    chk("t5_after_r3", 2, E(0, 0));
    chk("t5_after_r4", 3, E(0, 0));

    // Out-of-range addresses are ignored and read as zero
    ren(0, 40, 6); cmt(1, 34, 1, 32'hDEAD); rd(0, 40); rd(1, 34);
    chk("oor_ren", 0, E(0, 0));
    chk("oor_cmt", 1, E(0, 0));
    tick(); idle(); rd(0, 40); rd(1, 34);
    chk("oor_next", 1, E(0, 0));

`ifdef RENAME_RF_CKPT_EN
    // T6: checkpoint, later rename, recover with a matching commit
    ren(0, 4, 1); ckpt_save = 1'b1;
    tick(); idle();
    ren(0, 4, 5); rd(0, 4);
    chk("t6_young", 0, E(1, 5));
    tick(); idle();
    ckpt_recover = 1'b1; cmt(0, 4, 1, 32'h33); rd(0, 4);
    chk("t6_recover", 0, E(0, 32'h33));
    tick(); idle(); rd(0, 4);
    chk("t6_after", 0, E(0, 32'h33));
`endif

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      idle();
      rst = ($urandom_range(0, 39) != 0);
      for (int c = 0; c < NWR; c++)
        if ($urandom_range(0, 1) == 1) ren(c, raddr(), $urandom_range(0, 31));
      for (int c = 0; c < NCM; c++)
        if ($urandom_range(0, 1) == 1) begin
          a = raddr();
          cmt(c, a, (a < NREG && $urandom_range(0, 2) != 0) ? int'(m_id[a])
                                                           : $urandom_range(0, 31),
              $urandom);
        end
      restore = ($urandom_range(0, 15) == 0);
`ifdef RENAME_RF_CKPT_EN
      ckpt_save    = ($urandom_range(0, 5) == 0);
      ckpt_recover = ($urandom_range(0, 9) == 0);
`endif
      for (int p = 0; p < NRD; p++) rd(p, raddr());
      for (int p = 0; p < NRD; p++) chk("rand", p, m_read(rda[p]));
      tick();
    end

    // Reset clears everything again
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    rd(0, 5); rd(1, 2); rd(2, 6);
    chk("rst2_r5", 0, E(0, 0));
    chk("rst2_r2", 1, E(0, 0));
    chk("rst2_r6", 2, E(0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
